// File: rtl/cfg_req_drain_pkg.sv
// Shared definitions for the cfg-to-IOSF request drain: FIFO entry layout,
// FSM states and the unpacked request record.
package cfg_req_pkg;

  localparam int unsigned WR_BIT   = 68;
  localparam int unsigned BE_MSB   = 67;
  localparam int unsigned BE_LSB   = 64;
  localparam int unsigned ADDR_MSB = 63;
  localparam int unsigned ADDR_LSB = 32;
  localparam int unsigned DATA_MSB = 31;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    REQ,
    WAIT_CPL,
    RSP
  } state_e;

  typedef struct packed {
    logic        write;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cfg_req_t;

endpackage

// File: rtl/cfg_req_drain_if.sv
// Request / completion / response bundle between the drain and the IOSF side.
interface cfg_req_drain_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        cpl_valid;
  logic [31:0] cpl_data;
  logic        cpl_err;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;

  modport master (
    output req_valid, req_write, req_be, req_addr, req_wdata,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  req_ready, cpl_valid, cpl_data, cpl_err
  );

  modport slave (
    input  req_valid, req_write, req_be, req_addr, req_wdata,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output req_ready, cpl_valid, cpl_data, cpl_err
  );
endinterface

// File: rtl/cfg_req_drain_timer.sv
// Completion timeout counter: clear on request accept, count while enabled,
// saturate at all-ones so a stalled enable can never wrap back into range.
module cfg_req_timer #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TO_CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + TO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == TO_CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cfg_req_drain.sv
// Drains the cfg-to-IOSF CDC FIFO one config request at a time, waits for the
// completion (or a timeout) and pulses a response.
module cfg_req_drain
  import cfg_req_pkg::*;
#(
  parameter int unsigned DATA_W      = 69,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TO_CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_rdempty,
  output logic              fifo_rdreq,
  cfg_req_drain_if.master   bus,
  output logic              stray_cpl,
  output logic              busy
);

  state_e      state_q, state_d;
  cfg_req_t    req_q, req_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_to_q, rsp_to_d;
  logic        stray_q, stray_d;
  logic        rdreq;
  logic        tmr_clr, tmr_en, tmr_expire;

  cfg_req_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_CNT_W   (TO_CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    stray_d     = stray_q | (bus.cpl_valid && (state_q != WAIT_CPL));
    rdreq       = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_rdempty) begin
          rdreq   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        req_d.write = fifo_q[WR_BIT];
        req_d.be    = fifo_q[BE_MSB:BE_LSB];
        req_d.addr  = fifo_q[ADDR_MSB:ADDR_LSB];
        req_d.wdata = fifo_q[DATA_MSB:0];
        state_d     = REQ;
      end
      REQ: begin
        if (bus.req_ready) begin
          tmr_clr = 1'b1;
          state_d = WAIT_CPL;
        end
      end
      WAIT_CPL: begin
        tmr_en = 1'b1;
        // Completion is checked first so it wins a tie with expiry.
        if (bus.cpl_valid) begin
          rsp_rdata_d = req_q.write ? '0 : bus.cpl_data;
          rsp_err_d   = bus.cpl_err;
          rsp_to_d    = 1'b0;
          state_d     = RSP;
        end else if (tmr_expire) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      stray_q     <= stray_d;
    end
  end

  // IDLE is also the reset state, so gate the pop with rst_n to keep it low in reset.
  assign fifo_rdreq      = rdreq && rst_n;
  assign bus.req_valid   = (state_q == REQ);
  assign bus.req_write   = req_q.write;
  assign bus.req_be      = req_q.be;
  assign bus.req_addr    = req_q.addr;
  assign bus.req_wdata   = req_q.wdata;
  assign bus.rsp_valid   = (state_q == RSP);
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;
  assign stray_cpl       = stray_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_cfg_req_drain.sv
// Self-checking bench for cfg_req_drain: queue-based FIFO model, reactive
// IOSF-side driver and a rule-level reference for expected responses.
module tb_cfg_req_drain;

  localparam int T   = 8;
  localparam int CLK = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [68:0] fifo_q = '0;
  logic        fifo_rdempty;
  logic        fifo_rdreq;
  logic        stray_cpl;
  logic        busy;

  cfg_req_drain_if bif ();

  cfg_req_drain #(
    .DATA_W     (69),
    .TIMEOUT_CYC(T),
    .TO_CNT_W   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_q      (fifo_q),
    .fifo_rdempty(fifo_rdempty),
    .fifo_rdreq  (fifo_rdreq),
    .bus         (bif),
    .stray_cpl   (stray_cpl),
    .busy        (busy)
  );

  always #(CLK/2) clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [68:0] fifo_mem[$];
  int pushed    = 0;
  int popped    = 0;
  int rdreq_cnt = 0;
  int empty_pop = 0;

  assign fifo_rdempty = (pushed == popped);

  always @(posedge clk) begin
    if (fifo_rdreq) begin
      rdreq_cnt++;
      if (fifo_rdempty) begin
        empty_pop++;
      end else begin
        fifo_q <= fifo_mem.pop_front();
        popped <= popped + 1;
      end
    end
  end

  task automatic push(input logic [68:0] e);
    fifo_mem.push_back(e);
    pushed++;
  endtask

  typedef struct {
    bit          got_req;
    logic [68:0] f;
    int          held;
    bit          unstable;
    bit          got_rsp;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    bit          pulse_ok;
    bit          hold_ok;
    longint      rsp_t;
  } obs_t;

  // Drives one transaction from the IOSF side and records what the DUT did.
  // lat counts clocks from the first WAIT_CPL cycle to the rsp_valid cycle.
  task automatic serve(input int bp, input int d, input bit send,
                       input logic [31:0] cdata, input logic cerr, output obs_t o);
    o = '{default: '0};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.req_valid) begin
        o.got_req = 1'b1;
        break;
      end
    end
    if (!o.got_req) return;
    o.f    = {bif.req_write, bif.req_be, bif.req_addr, bif.req_wdata};
    o.held = 1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (bif.req_valid) o.held++;
      if ({bif.req_write, bif.req_be, bif.req_addr, bif.req_wdata} !== o.f) o.unstable = 1'b1;
    end
    bif.req_ready = 1'b1;
    @(negedge clk);
    bif.req_ready = 1'b0;
    for (int k = 0; k < T + 20; k++) begin
      if (send && k == d) begin
        bif.cpl_valid = 1'b1;
        bif.cpl_data  = cdata;
        bif.cpl_err   = cerr;
      end
      @(negedge clk);
      bif.cpl_valid = 1'b0;
      if (bif.rsp_valid) begin
        o.got_rsp = 1'b1;
        o.lat     = k + 1;
        o.rdata   = bif.rsp_rdata;
        o.err     = bif.rsp_err;
        o.to      = bif.rsp_timeout;
        o.rsp_t   = $time;
        break;
      end
    end
    if (!o.got_rsp) return;
    @(negedge clk);
    o.pulse_ok = !bif.rsp_valid;
    o.hold_ok  = (bif.rsp_rdata === o.rdata) && (bif.rsp_err === o.err) && (bif.rsp_timeout === o.to);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fifo_rdreq, bif.req_valid, bif.req_write, bif.req_be, bif.req_addr, bif.req_wdata,
         bif.rsp_valid, bif.rsp_rdata, bif.rsp_err, bif.rsp_timeout, stray_cpl, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdreq=%b rv=%b addr=%h rsp=%b stray=%b busy=%b exp all 0",
               fifo_rdreq, bif.req_valid, bif.req_addr, bif.rsp_valid, stray_cpl, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_single_read;
    obs_t o;
    int   c0 = rdreq_cnt;
    push({1'b0, 4'hF, 32'h0000_0010, 32'h0});
    serve(0, 3, 1'b1, 32'hDEAD_BEEF, 1'b0, o);
    n_checks++;
    if (!o.got_req || !o.got_rsp) begin n_fail++; $display("FAIL rd_handshake got req=%b rsp=%b exp 1 1", o.got_req, o.got_rsp); end
    n_checks++;
    if (o.f[63:32] !== 32'h10) begin n_fail++; $display("FAIL rd_addr got %h exp %h", o.f[63:32], 32'h10); end
    n_checks++;
    if (rdreq_cnt - c0 !== 1) begin n_fail++; $display("FAIL rd_rdreq_pulses got %0d exp 1", rdreq_cnt - c0); end
    n_checks++;
    if ({o.rdata, o.err, o.to} !== {32'hDEAD_BEEF, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rd_rsp got %h/%b/%b exp deadbeef/0/0", o.rdata, o.err, o.to);
    end
    n_checks++;
    if (o.lat !== 4) begin n_fail++; $display("FAIL rd_latency got %0d exp 4", o.lat); end
    n_checks++;
    if (!o.pulse_ok || !o.hold_ok) begin n_fail++; $display("FAIL rd_pulse got pulse_ok=%b hold_ok=%b exp 1 1", o.pulse_ok, o.hold_ok); end
  endtask

  task automatic test_write_backpressure;
    obs_t o;
    logic [68:0] e = {1'b1, 4'h3, 32'h0000_0104, 32'h1234_5678};
    push(e);
    serve(7, 2, 1'b1, 32'hFFFF_0000, 1'b1, o);
    n_checks++;
    if (o.held !== 8) begin n_fail++; $display("FAIL wr_held_cycles got %0d exp 8", o.held); end
    n_checks++;
    if (o.unstable !== 1'b0) begin n_fail++; $display("FAIL wr_fields_stable got unstable=%b exp 0", o.unstable); end
    n_checks++;
    if (o.f !== e) begin n_fail++; $display("FAIL wr_fields got %h exp %h", o.f, e); end
    n_checks++;
    if ({o.got_rsp, o.rdata, o.err, o.to} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL wr_rsp got %b/%h/%b/%b exp 1/0/1/0", o.got_rsp, o.rdata, o.err, o.to);
    end
  endtask

  task automatic test_tie_at_expiry;
    obs_t o;
    push({1'b0, 4'hF, 32'h0000_0200, 32'h0});
    serve(0, T - 1, 1'b1, 32'hA5A5_A5A5, 1'b0, o);
    n_checks++;
    if ({o.got_rsp, o.rdata, o.err, o.to} !== {1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL tie_rsp got %b/%h/%b/%b exp 1/a5a5a5a5/0/0", o.got_rsp, o.rdata, o.err, o.to);
    end
    n_checks++;
    if (o.lat !== T) begin n_fail++; $display("FAIL tie_latency got %0d exp %0d", o.lat, T); end
  endtask

  task automatic test_back_to_back;
    obs_t        o;
    logic [68:0] exp_q[$];
    longint      prev_t = 0;
    int          e0 = empty_pop;
    for (int i = 0; i < 4; i++) begin
      logic [68:0] e = {1'b0, 4'hF, 32'h0000_1000 + 32'(i * 4), $urandom()};
      exp_q.push_back(e);
      push(e);
    end
    for (int i = 0; i < 4; i++) begin
      logic [68:0] e = exp_q.pop_front();
      logic [31:0] cd = $urandom();
      serve(0, 0, 1'b1, cd, 1'b0, o);
      n_checks++;
      if (o.f !== e) begin n_fail++; $display("FAIL b2b_order[%0d] got %h exp %h", i, o.f, e); end
      n_checks++;
      if ({o.got_rsp, o.rdata} !== {1'b1, cd}) begin n_fail++; $display("FAIL b2b_rdata[%0d] got %b/%h exp 1/%h", i, o.got_rsp, o.rdata, cd); end
      if (i > 0) begin
        n_checks++;
        if (o.rsp_t - prev_t !== longint'(5 * CLK)) begin
          n_fail++; $display("FAIL b2b_spacing[%0d] got %0d exp %0d", i, o.rsp_t - prev_t, 5 * CLK);
        end
      end
      prev_t = o.rsp_t;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (empty_pop - e0 !== 0) begin n_fail++; $display("FAIL b2b_pop_empty got %0d exp 0", empty_pop - e0); end
  endtask

  task automatic test_random;
    obs_t o;
    for (int n = 0; n < 24; n++) begin
      logic [68:0] e  = {$urandom_range(0, 1) == 1, 4'($urandom()), $urandom(), $urandom()};
      int          bp = $urandom_range(0, 3);
      int          d  = $urandom_range(0, T + 2);
      bit          ok = (d <= T - 1);
      logic [31:0] cd = $urandom();
      logic        ce = ($urandom_range(0, 3) == 0);
      logic [31:0] x_rd  = ok ? (e[68] ? 32'h0 : cd) : 32'h0;
      logic        x_err = ok ? ce : 1'b1;
      logic        x_to  = !ok;
      int          x_lat = ok ? d + 1 : T;
      push(e);
      serve(bp, d, ok, cd, ce, o);
      n_checks++;
      if (o.f !== e || o.held !== bp + 1) begin
        n_fail++; $display("FAIL rnd_req[%0d] got %h held %0d exp %h held %0d", n, o.f, o.held, e, bp + 1);
      end
      n_checks++;
      if ({o.got_rsp, o.rdata, o.err, o.to} !== {1'b1, x_rd, x_err, x_to} || o.lat !== x_lat) begin
        n_fail++; $display("FAIL rnd_rsp[%0d] got %b/%h/%b/%b lat %0d exp 1/%h/%b/%b lat %0d",
                           n, o.got_rsp, o.rdata, o.err, o.to, o.lat, x_rd, x_err, x_to, x_lat);
      end
    end
  endtask

  task automatic test_timeout_stray;
    obs_t o;
    push({1'b0, 4'h1, 32'h0000_0300, 32'h0});
    serve(0, 0, 1'b0, 32'h0, 1'b0, o);
    n_checks++;
    if ({o.got_rsp, o.rdata, o.err, o.to} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL to_rsp got %b/%h/%b/%b exp 1/0/1/1", o.got_rsp, o.rdata, o.err, o.to);
    end
    n_checks++;
    if (o.lat !== T) begin n_fail++; $display("FAIL to_latency got %0d exp %0d", o.lat, T); end
    n_checks++;
    if (stray_cpl !== 1'b0) begin n_fail++; $display("FAIL stray_before got %b exp 0", stray_cpl); end
    bif.cpl_valid = 1'b1;
    bif.cpl_data  = 32'h1111_2222;
    @(negedge clk);
    bif.cpl_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stray_cpl !== 1'b1) begin n_fail++; $display("FAIL stray_after got %b exp 1", stray_cpl); end
    n_checks++;
    if ({bif.rsp_rdata, bif.rsp_timeout} !== {32'h0, 1'b1}) begin
      n_fail++; $display("FAIL stray_no_data got %h/%b exp 0/1", bif.rsp_rdata, bif.rsp_timeout);
    end
  endtask

  task automatic test_reset_midop;
    obs_t        o;
    bit          seen = 1'b0;
    logic [68:0] eb = {1'b0, 4'hC, 32'h0000_0400, 32'h0};
    push({1'b1, 4'hF, 32'h0000_03F0, 32'hCAFE_F00D});
    push(eb);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.req_valid) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL mid_req_seen got 0 exp 1"); end
    bif.req_ready = 1'b1;
    @(negedge clk);
    bif.req_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fifo_rdreq, bif.req_valid, bif.req_write, bif.req_be, bif.req_addr, bif.req_wdata,
         bif.rsp_valid, bif.rsp_rdata, bif.rsp_err, bif.rsp_timeout, stray_cpl, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got rdreq=%b rv=%b addr=%h rsp=%b rd=%h stray=%b busy=%b exp all 0",
               fifo_rdreq, bif.req_valid, bif.req_addr, bif.rsp_valid, bif.rsp_rdata, stray_cpl, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    serve(0, 1, 1'b1, 32'h7777_8888, 1'b0, o);
    n_checks++;
    if (o.f !== eb) begin n_fail++; $display("FAIL mid_next_entry got %h exp %h", o.f, eb); end
    n_checks++;
    if ({o.got_rsp, o.rdata, o.err, o.to} !== {1'b1, 32'h7777_8888, 1'b0, 1'b0} || o.lat !== 2) begin
      n_fail++; $display("FAIL mid_next_rsp got %b/%h/%b/%b lat %0d exp 1/77778888/0/0 lat 2",
                         o.got_rsp, o.rdata, o.err, o.to, o.lat);
    end
    n_checks++;
    if (empty_pop !== 0) begin n_fail++; $display("FAIL pop_while_empty got %0d exp 0", empty_pop); end
  endtask

  initial begin
    rst_n         = 1'b0;
    bif.req_ready = 1'b0;
    bif.cpl_valid = 1'b0;
    bif.cpl_data  = '0;
    bif.cpl_err   = 1'b0;
    test_reset();
    test_single_read();
    test_write_backpressure();
    test_tie_at_expiry();
    test_back_to_back();
    test_random();
    test_timeout_stray();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cfg_req_drain.md
Name: cfg_req_drain

Overview:
- Single-clock reader at the IOSF-side end of the 69-bit cfg-to-IOSF CDC FIFO.
- Pops one config request at a time and presents it on a valid/ready request port.
- Waits for the matching completion, with a timeout, then pulses a response with read data and error status.
- One request outstanding at a time; the FIFO provides the buffering.

Parameters:
- DATA_W, 69, FIFO entry width; fixed layout below, must stay 69.
- TIMEOUT_CYC, 1024, cycles allowed from request accept to completion; legal range 2..65535.
- TO_CNT_W, 16, width of the timeout counter; must satisfy 2**TO_CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  block clock; same clock as the FIFO read side (rdclk).
- rst_n  in  1  asynchronous, active-low reset.
- fifo_q  in  69  FIFO read data; normal (non-show-ahead) mode, valid the cycle after fifo_rdreq.
- fifo_rdempty  in  1  FIFO empty flag.
- fifo_rdreq  out  1  FIFO pop strobe.
- req_valid  out  1  request valid.
- req_ready  in  1  downstream accept.
- req_write  out  1  1 = write, 0 = read.
- req_be  out  4  byte enables.
- req_addr  out  32  config address.
- req_wdata  out  32  write data.
- cpl_valid  in  1  completion strobe, single cycle.
- cpl_data  in  32  completion read data.
- cpl_err  in  1  completion error.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  read data; 0 for writes and timeouts.
- rsp_err  out  1  error (cpl_err or timeout).
- rsp_timeout  out  1  response was generated by timeout.
- stray_cpl  out  1  sticky; set when cpl_valid arrives outside WAIT_CPL.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Entry layout: [68] write, [67:64] be, [63:32] addr, [31:0] wdata.
- Reset: every output is 0, FSM goes to IDLE, timer is 0, stray_cpl is cleared.
- Reset mid-operation abandons the in-flight entry. FIFO aclr is handled outside this block.
- FSM states:
  - IDLE: if fifo_rdempty==0, drive fifo_rdreq=1 for exactly one cycle and go to FETCH. Otherwise stay.
  - FETCH: register fifo_q into the req_* fields, go to REQ. fifo_rdreq=0.
  - REQ: req_valid=1 with all req_* fields stable until handshake. On req_valid&&req_ready, go to WAIT_CPL and clear the timer. req_valid is never withdrawn before acceptance.
  - WAIT_CPL: timer increments each cycle.
    - cpl_valid: go to RSP; rsp_rdata = req_write ? 0 : cpl_data; rsp_err = cpl_err; rsp_timeout = 0.
    - Otherwise, timer == TIMEOUT_CYC-1: go to RSP; rsp_rdata = 0; rsp_err = 1; rsp_timeout = 1.
    - cpl_valid in the same cycle as expiry: the completion wins.
  - RSP: rsp_valid=1 for one cycle, then IDLE. rsp_* fields hold their value until the next response.
- fifo_rdreq is never asserted while fifo_rdempty=1, and never asserted outside IDLE.
- Minimum per-request cycle with req_ready=1 and a completion one cycle after accept: IDLE, FETCH, REQ, WAIT_CPL, RSP = 5 cycles.
- req_* fields are don't-care outside REQ but hold their last value; no glitching.
- cpl_valid in IDLE/FETCH/REQ/RSP is ignored for data and sets stray_cpl (cleared only by reset).
- Timer saturates and never wraps.

Decomposition:
- Package cfg_req_pkg holds:
  - field offset constants (WR_BIT=68, BE_MSB=67, BE_LSB=64, ADDR_MSB=63, ADDR_LSB=32, DATA_MSB=31);
  - the FSM state enum (IDLE, FETCH, REQ, WAIT_CPL, RSP);
  - a packed struct cfg_req_t {write, be[3:0], addr[31:0], wdata[31:0]}.
- One sub-module, cfg_req_timer: clear/enable/expire counter parameterised by TIMEOUT_CYC and TO_CNT_W. The rest stays flat.

Test Plan:
- Single read: push {0,4'hF,32'h0000_0010,32'h0} with req_ready=1; completion data 32'hDEAD_BEEF arrives 3 cycles after accept -> exactly one fifo_rdreq pulse, req_addr=0x10, then rsp_valid pulse with rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_timeout=0.
- Write with backpressure: entry {1,4'h3,0x104,0x1234_5678}; req_ready low for 7 cycles -> req_valid held high with stable fields for 8 cycles; cpl_err=1 -> rsp_rdata=0, rsp_err=1.
- Timeout: TIMEOUT_CYC=8, no completion -> rsp_valid exactly 8 cycles after accept, with rsp_err=1 and rsp_timeout=1. A late cpl_valid afterwards sets stray_cpl.
- Tie at expiry: cpl_valid on the expiry cycle with cpl_data=0xA5A5A5A5 -> rsp_timeout=0, rsp_rdata=0xA5A5A5A5.
- Back-to-back: 4 entries queued, req_ready=1, 1-cycle completions -> 4 rsp pulses spaced 5 cycles apart, addresses in FIFO order, fifo_rdreq never asserted while empty.
- Reset mid-op: assert rst_n=0 during WAIT_CPL -> all outputs 0 asynchronously; after release, block is IDLE and the next FIFO entry is processed normally.
